// File: rtl/sb_tx_arbiter_if.sv
// Sideband transmit arbiter bus: requester handshake, serializer handshake
// and encoder-mux outputs grouped as one interface.
interface sb_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [64*NUM_REQ-1:0] i_req_packet;
  logic [NUM_REQ-1:0]    i_req_needs_rsp;
  logic [NUM_REQ-1:0]    o_req_grant;
  logic                  i_pattern_active;
  logic                  i_ser_done;
  logic                  o_packet_valid;
  logic [63:0]           o_framed_packet_phase;
  logic                  o_timeout_ctr_start;
  logic                  o_busy;

  // Arbiter side.
  modport slave (
    input  i_req_valid,
    input  i_req_packet,
    input  i_req_needs_rsp,
    input  i_pattern_active,
    input  i_ser_done,
    output o_req_grant,
    output o_packet_valid,
    output o_framed_packet_phase,
    output o_timeout_ctr_start,
    output o_busy
  );

  // Requester / serializer / encoder side.
  modport master (
    output i_req_valid,
    output i_req_packet,
    output i_req_needs_rsp,
    output i_pattern_active,
    output i_ser_done,
    input  o_req_grant,
    input  o_packet_valid,
    input  o_framed_packet_phase,
    input  o_timeout_ctr_start,
    input  o_busy
  );
endinterface

// File: rtl/sb_tx_arbiter.sv
// Sideband transmit arbiter: round-robin selection among packet requesters,
// latches the winning 64-bit framed packet, presents it to the encoder mux
// until the serializer reports completion, then enforces an idle gap.
// Defers to the pattern generator while it owns the serializer.
module sb_tx_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sb_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [3:0]            gap_cnt_r;

  logic                  pick_found_s;
  logic [PTR_W-1:0]      pick_idx_s;
  logic [63:0]           pick_pkt_s;
  logic                  pick_rsp_s;
  logic [NUM_REQ-1:0]    pick_onehot_s;
  logic [PTR_W-1:0]      ptr_after_s;

  logic                  do_grant_s;
  logic                  gap_load_s;
  logic                  gap_dec_s;

  logic [NUM_REQ-1:0]    grant_r;
  logic [63:0]           packet_r;
  logic                  pkt_valid_r;
  logic                  tmo_start_r;
  logic                  busy_r;

  // Round-robin pick: returns {found, index} of the first valid requester
  // scanning ptr, ptr+1, ... modulo NUM_REQ. Scanning from the farthest
  // offset down lets the nearest valid requester overwrite the result.
  function automatic logic [PTR_W:0] rr_pick(
    input logic [NUM_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr
  );
    logic [PTR_W:0]   res;
    logic [PTR_W-1:0] sel;
    int unsigned      idx;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
      sel = PTR_W'(idx);
      res = valid[sel] ? {1'b1, sel} : res;
    end
    return res;
  endfunction

  assign {pick_found_s, pick_idx_s} = rr_pick(bus.i_req_valid, rr_ptr_r);
  assign pick_pkt_s    = bus.i_req_packet[{pick_idx_s, 6'd0} +: 64];
  assign pick_rsp_s    = bus.i_req_needs_rsp[pick_idx_s];
  assign pick_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
  assign ptr_after_s   = (pick_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + 1'b1;

  // Next-state and control decode; ser_done only matters in SEND, and the
  // pattern generator blocks new grants only while IDLE.
  always_comb begin
    state_nxt_s = state_r;
    do_grant_s  = 1'b0;
    gap_load_s  = 1'b0;
    gap_dec_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.i_pattern_active && pick_found_s) begin
          do_grant_s  = 1'b1;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (bus.i_ser_done) begin
          gap_load_s  = 1'b1;
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = SEND;
        end
      end
      GAP: begin
        gap_dec_s = 1'b1;
        if (gap_cnt_r <= 4'd1) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GAP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer advances past each winner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_r <= '0;
    end else if (do_grant_s) begin
      rr_ptr_r <= ptr_after_s;
    end
  end

  // Idle-gap counter: loaded when the serializer finishes, counts down in GAP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap_cnt_r <= 4'd0;
    end else if (gap_load_s) begin
      gap_cnt_r <= 4'(GAP_CYCLES);
    end else if (gap_dec_s) begin
      gap_cnt_r <= gap_cnt_r - 4'd1;
    end else begin
      gap_cnt_r <= 4'd0;
    end
  end

  // Registered outputs: grant and timeout-start pulse only on the grant edge,
  // packet latched on grant and held, valid/busy follow the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_r     <= '0;
      packet_r    <= 64'd0;
      pkt_valid_r <= 1'b0;
      tmo_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      grant_r     <= do_grant_s ? pick_onehot_s : '0;
      packet_r    <= do_grant_s ? pick_pkt_s : packet_r;
      pkt_valid_r <= (state_nxt_s == SEND);
      tmo_start_r <= do_grant_s & pick_rsp_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign bus.o_req_grant           = grant_r;
  assign bus.o_framed_packet_phase = packet_r;
  assign bus.o_packet_valid        = pkt_valid_r;
  assign bus.o_timeout_ctr_start   = tmo_start_r;
  assign bus.o_busy                = busy_r;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter (NUM_REQ=3, GAP_CYCLES=4).
module tb_sb_tx_arbiter;
  localparam int NR  = 3;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] pk [3];

  sb_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  sb_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] grant, input logic pv,
                            input logic tmo, input logic busy);
    check_eq({tag, "/grant"}, 64'(bus.o_req_grant), 64'(grant));
    check_eq({tag, "/pvalid"}, 64'(bus.o_packet_valid), 64'(pv));
    check_eq({tag, "/tmo"}, 64'(bus.o_timeout_ctr_start), 64'(tmo));
    check_eq({tag, "/busy"}, 64'(bus.o_busy), 64'(busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a SEND cycle: pulses ser_done there (cycle D), then walks the
  // gap D+1..D+4 and the first IDLE cycle D+5. Optionally pulses ser_done
  // again inside GAP, which must not disturb the gap length.
  task automatic send_done(input string tag, input bit sd_in_gap);
    bus.i_ser_done = 1'b1;
    tick();
    bus.i_ser_done = 1'b0;
    check_outs({tag, "_gap1"}, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < GAP - 1; i++) begin
      bus.i_ser_done = sd_in_gap && (i == 0);
      tick();
      bus.i_ser_done = 1'b0;
      check_outs({tag, "_gapn"}, 3'b000, 1'b0, 1'b0, 1'b1);
    end
    tick();
    check_outs({tag, "_idle"}, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pk[0] = 64'h0123_4567_89AB_CDEF;
    pk[1] = 64'hA5A5_0000_1234_5678;
    pk[2] = 64'hDEAD_BEEF_CAFE_F00D;
    rst = 1'b1;
    bus.i_req_valid      = 3'b000;
    bus.i_req_packet     = {pk[2], pk[1], pk[0]};
    bus.i_req_needs_rsp  = 3'b000;
    bus.i_pattern_active = 1'b0;
    bus.i_ser_done       = 1'b0;

    // Reset state.
    tick();
    tick();
    check_outs("reset", 3'b000, 1'b0, 1'b0, 1'b0);
    check_eq("reset/pkt", bus.o_framed_packet_phase, 64'h0);
    rst = 1'b0;
    tick();

    // ser_done while IDLE is ignored.
    bus.i_ser_done = 1'b1;
    tick();
    bus.i_ser_done = 1'b0;
    check_outs("idle_sd", 3'b000, 1'b0, 1'b0, 1'b0);

    // Single request from requester 1, ser_done 10 cycles after grant.
    bus.i_req_valid = 3'b010;
    tick();
    check_outs("single_grant", 3'b010, 1'b1, 1'b0, 1'b1);
    check_eq("single_grant/pkt", bus.o_framed_packet_phase, pk[1]);
    bus.i_req_valid = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_outs("single_send", 3'b000, 1'b1, 1'b0, 1'b1);
      check_eq("single_send/pkt", bus.o_framed_packet_phase, pk[1]);
    end
    bus.i_req_valid = 3'b010;
    send_done("single", 1'b1);
    tick();
    check_outs("single_next", 3'b010, 1'b1, 1'b0, 1'b1);
    bus.i_req_valid = 3'b000;
    tick();
    send_done("single2", 1'b0);

    // Pattern generator active, rising together with requester 2's valid.
    bus.i_req_valid      = 3'b100;
    bus.i_pattern_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_outs("pattern_hold", 3'b000, 1'b0, 1'b0, 1'b0);
    end
    bus.i_pattern_active = 1'b0;
    tick();
    check_outs("pattern_grant", 3'b100, 1'b1, 1'b0, 1'b1);
    check_eq("pattern_grant/pkt", bus.o_framed_packet_phase, pk[2]);
    bus.i_req_valid      = 3'b000;
    bus.i_pattern_active = 1'b1;
    tick();
    tick();
    check_outs("pattern_in_send", 3'b000, 1'b1, 1'b0, 1'b1);
    send_done("pattern", 1'b0);
    bus.i_pattern_active = 1'b0;

    // Round robin with all requesters valid from reset; requester 0 needs a response.
    bus.i_req_needs_rsp = 3'b001;
    bus.i_req_valid     = 3'b111;
    rst = 1'b1;
    tick();
    check_outs("rr_rst", 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      check_outs("rr_grant", 3'(3'b001 << (k % 3)), 1'b1, (k % 3) == 0, 1'b1);
      check_eq("rr_grant/pkt", bus.o_framed_packet_phase, pk[k % 3]);
      tick();
      check_outs("rr_hold", 3'b000, 1'b1, 1'b0, 1'b1);
      check_eq("rr_hold/pkt", bus.o_framed_packet_phase, pk[k % 3]);
      tick();
      send_done("rr", 1'b0);
      tick();
    end
    check_outs("rr_wrap", 3'b001, 1'b1, 1'b1, 1'b1);

    // Reset three cycles into SEND with requesters 0 and 2 pending.
    tick();
    tick();
    bus.i_req_valid = 3'b101;
    bus.i_ser_done  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ser_done = 1'b0;
    check_outs("midrst", 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("midrst_grant", 3'b001, 1'b1, 1'b1, 1'b1);
    check_eq("midrst_grant/pkt", bus.o_framed_packet_phase, pk[0]);
    bus.i_req_valid = 3'b000;
    tick();
    send_done("final", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
